// File: rtl/seg_pkg.sv
// Shared types for the segmentation argmax stream: score type, FSM encoding and defaults.
// Optional build macro used by the block: SEG_CONFIDENCE_EN (adds the m_margin output).
package seg_pkg;

    localparam int SEG_SCORE_W      = 16;
    localparam int SEG_IGNORE_LABEL = 255;

    typedef logic signed [SEG_SCORE_W-1:0] score_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Counter/index width for a range of n values; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_lane_max.sv
// Combinational signed max across the lanes of one input beat; lowest lane wins ties.
// With SEG_CONFIDENCE_EN defined it also returns the second-best score of the beat.
module seg_lane_max
    import seg_pkg::*;
#(
    parameter int LANES   = 3,
    parameter int SCORE_W = 16,
    parameter int LANE_W  = 2
) (
    input  logic [LANES*SCORE_W-1:0]  data,
    output logic signed [SCORE_W-1:0] best,
    output logic [LANE_W-1:0]         best_lane
`ifdef SEG_CONFIDENCE_EN
    ,
    output logic signed [SCORE_W-1:0] second
`endif
);

    logic signed [SCORE_W-1:0] lane;

    // NOTE: every output gets a value before the loop so no path leaves one unassigned (no latch).
    always_comb begin
        best      = data[SCORE_W-1:0];
        best_lane = '0;
        lane      = '0;
`ifdef SEG_CONFIDENCE_EN
        second    = {1'b1, {(SCORE_W-1){1'b0}}};
`endif
        for (int i = 1; i < LANES; i++) begin
            lane = data[i*SCORE_W +: SCORE_W];
            if (lane > best) begin
`ifdef SEG_CONFIDENCE_EN
                second = best;
`endif
                best      = lane;
                best_lane = LANE_W'(i);
            end
`ifdef SEG_CONFIDENCE_EN
            else if (lane > second) begin
                second = lane;
            end
`endif
        end
    end

endmodule

// File: rtl/seg_argmax_stream.sv
// Streaming per-pixel argmax over class scores with a confidence threshold and a one-label output register.
// Optional build macro: SEG_CONFIDENCE_EN adds m_margin (winning minus runner-up score).
module seg_argmax_stream
    import seg_pkg::*;
#(
    parameter int NUM_CLASSES  = 21,
    parameter int LANES        = 3,
    parameter int SCORE_W      = 16,
    parameter int NUM_PIXELS   = 50176,
    parameter int LABEL_W      = 8,
    parameter int IGNORE_LABEL = SEG_IGNORE_LABEL
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic signed [SCORE_W-1:0] thresh,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [LANES*SCORE_W-1:0]  s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [LABEL_W-1:0]        m_label,
    output logic                      m_last,
`ifdef SEG_CONFIDENCE_EN
    output logic [SCORE_W-1:0]        m_margin,
`endif
    output logic                      busy,
    output logic                      done
);

    localparam int BEATS  = NUM_CLASSES / LANES;
    localparam int BEAT_W = clog2_min1(BEATS);
    localparam int PIX_W  = clog2_min1(NUM_PIXELS);
    localparam int LANE_W = clog2_min1(LANES);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(NUM_PIXELS - 1);

    state_t                    state_q, state_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [PIX_W-1:0]          pix_q, pix_d;
    logic signed [SCORE_W-1:0] thresh_q, thresh_d;
    logic signed [SCORE_W-1:0] max_q, max_d;
    logic [LABEL_W-1:0]        idx_q, idx_d;
    logic                      m_valid_q, m_valid_d;
    logic [LABEL_W-1:0]        m_label_q, m_label_d;
    logic                      m_last_q, m_last_d;

    logic signed [SCORE_W-1:0] lane_best;
    logic [LANE_W-1:0]         lane_idx;
    logic                      final_beat, accept, take;
    logic signed [SCORE_W-1:0] upd_max;
    logic [LABEL_W-1:0]        upd_idx;

`ifdef SEG_CONFIDENCE_EN
    logic signed [SCORE_W-1:0] sec_q, sec_d;
    logic [SCORE_W-1:0]        m_margin_q, m_margin_d;
    logic signed [SCORE_W-1:0] lane_sec;
    logic signed [SCORE_W-1:0] upd_sec;
    logic signed [SCORE_W:0]   diff;
    logic [SCORE_W-1:0]        margin;
`endif

    seg_lane_max #(
        .LANES   (LANES),
        .SCORE_W (SCORE_W),
        .LANE_W  (LANE_W)
    ) u_lane_max (
        .data      (s_data),
        .best      (lane_best),
        .best_lane (lane_idx)
`ifdef SEG_CONFIDENCE_EN
        ,
        .second    (lane_sec)
`endif
    );

    assign final_beat = (beat_q == LAST_BEAT);
    // Only the final beat can stall: it is the one that must write the occupied output register.
    assign s_ready    = (state_q == ST_RUN) && !(final_beat && m_valid_q && !m_ready);
    assign accept     = s_valid && s_ready;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FLUSH) && m_valid_q && m_ready;

    assign m_valid = m_valid_q;
    assign m_label = m_label_q;
    assign m_last  = m_last_q;

    // Running max: the first beat of a pixel reloads it; later beats need a strictly greater score.
    always_comb begin
        take    = (beat_q == '0) || (lane_best > max_q);
        upd_max = take ? lane_best : max_q;
        upd_idx = take ? LABEL_W'(int'(beat_q) * LANES + int'(lane_idx)) : idx_q;
    end

`ifdef SEG_CONFIDENCE_EN
    always_comb begin
        if (beat_q == '0) begin
            upd_sec = lane_sec;
        end else if (take) begin
            upd_sec = (max_q > lane_sec) ? max_q : lane_sec;
        end else begin
            upd_sec = (sec_q > lane_best) ? sec_q : lane_best;
        end
        diff   = (SCORE_W+1)'(upd_max) - (SCORE_W+1)'(upd_sec);
        margin = diff[SCORE_W] ? '1 : diff[SCORE_W-1:0];
    end

    assign m_margin = m_margin_q;
`endif

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        pix_d     = pix_q;
        thresh_d  = thresh_q;
        max_d     = max_q;
        idx_d     = idx_q;
        m_valid_d = m_valid_q;
        m_label_d = m_label_q;
        m_last_d  = m_last_q;
`ifdef SEG_CONFIDENCE_EN
        sec_d      = sec_q;
        m_margin_d = m_margin_q;
`endif

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    beat_d   = '0;
                    pix_d    = '0;
                    thresh_d = thresh;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    max_d = upd_max;
                    idx_d = upd_idx;
`ifdef SEG_CONFIDENCE_EN
                    sec_d = upd_sec;
`endif
                    if (final_beat) begin
                        beat_d    = '0;
                        m_valid_d = 1'b1;
                        m_label_d = (upd_max < thresh_q) ? LABEL_W'(IGNORE_LABEL) : upd_idx;
                        m_last_d  = (pix_q == LAST_PIX);
`ifdef SEG_CONFIDENCE_EN
                        m_margin_d = margin;
`endif
                        if (pix_q == LAST_PIX) begin
                            state_d = ST_FLUSH;
                            pix_d   = '0;
                        end else begin
                            pix_d = pix_q + 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (m_valid_q && m_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            pix_q     <= '0;
            thresh_q  <= '0;
            max_q     <= '0;
            idx_q     <= '0;
            m_valid_q <= 1'b0;
            m_label_q <= '0;
            m_last_q  <= 1'b0;
`ifdef SEG_CONFIDENCE_EN
            sec_q      <= '0;
            m_margin_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            pix_q     <= pix_d;
            thresh_q  <= thresh_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            m_valid_q <= m_valid_d;
            m_label_q <= m_label_d;
            m_last_q  <= m_last_d;
`ifdef SEG_CONFIDENCE_EN
            sec_q      <= sec_d;
            m_margin_q <= m_margin_d;
`endif
        end
    end

endmodule

// File: tb/tb_seg_argmax_stream.sv
// Directed bench for seg_argmax_stream: 4 classes, 2 lanes, 3 pixels; checks labels, threshold,
// backpressure, mid-frame reset and start-while-busy (plus m_margin when SEG_CONFIDENCE_EN is defined).
module tb_seg_argmax_stream;

    localparam int NC = 4;
    localparam int LN = 2;
    localparam int SW = 16;
    localparam int NP = 3;
    localparam int LW = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic signed [SW-1:0]  thresh;
    logic                  s_valid;
    logic                  s_ready;
    logic [LN*SW-1:0]      s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [LW-1:0]         m_label;
    logic                  m_last;
    logic                  busy;
    logic                  done;
`ifdef SEG_CONFIDENCE_EN
    logic [SW-1:0]         m_margin;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg_argmax_stream #(
        .NUM_CLASSES  (NC),
        .LANES        (LN),
        .SCORE_W      (SW),
        .NUM_PIXELS   (NP),
        .LABEL_W      (LW),
        .IGNORE_LABEL (255)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .thresh   (thresh),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_label  (m_label),
        .m_last   (m_last),
`ifdef SEG_CONFIDENCE_EN
        .m_margin (m_margin),
`endif
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one beat at a negedge and returns at the negedge after the edge that accepted it.
    task automatic send_beat(input int a, input int b);
        logic ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = {SW'(b), SW'(a)};
        for (int n = 0; n < 20 && !ok; n++) begin
            #1;
            ok = s_ready;
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_data  = '0;
        check("beat_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic send_pixel(input int a, input int b, input int c, input int d);
        send_beat(a, b);
        send_beat(c, d);
    endtask

    task automatic check_label(input string tag, input int label, input logic last, input logic dn);
        check({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
        check({tag, "_label"}, {24'd0, m_label}, 32'(label));
        check({tag, "_last"},  {31'd0, m_last},  {31'd0, last});
        check({tag, "_done"},  {31'd0, done},    {31'd0, dn});
    endtask

    task automatic do_start(input int th);
        start  = 1'b1;
        thresh = SW'(th);
        @(negedge clk);
        start  = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
        check({tag, "_busy"},    {31'd0, busy},    32'd0);
        check({tag, "_done"},    {31'd0, done},    32'd0);
        check({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        thresh  = '0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        #3;
        check_idle("reset");
        check("reset_label", {24'd0, m_label}, 32'd0);
        check("reset_last",  {31'd0, m_last},  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Beat offered in IDLE is refused and leaves no trace.
        s_valid = 1'b1;
        s_data  = {16'sd9, 16'sd5};
        #1;
        check("idle_s_ready", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        s_valid = 1'b0;
        check_idle("idle_beat");

        // Base frame.
        do_start(-32768);
        send_pixel(5, 9, -3, 2);
        check_label("f1_p0", 1, 1'b0, 1'b0);
`ifdef SEG_CONFIDENCE_EN
        check("f1_p0_margin", {16'd0, m_margin}, 32'd4);
`endif
        send_beat(-7, -7);
        check("f1_drain", {31'd0, m_valid}, 32'd0);
        send_beat(-9, -8);
        check_label("f1_p1", 0, 1'b0, 1'b0);
`ifdef SEG_CONFIDENCE_EN
        check("f1_p1_margin", {16'd0, m_margin}, 32'd0);
`endif
        send_pixel(0, 1, 1, 0);
        check_label("f1_p2", 1, 1'b1, 1'b1);
        check("f1_flush_s_ready", {31'd0, s_ready}, 32'd0);
        @(negedge clk);
        check_idle("f1_end");

        // Threshold above the winner, then equal to it.
        do_start(10);
        send_pixel(5, 9, -3, 2);
        check_label("th10_p0", 255, 1'b0, 1'b0);
        send_pixel(-7, -7, -9, -8);
        send_pixel(0, 1, 1, 0);
        check_label("th10_p2", 255, 1'b1, 1'b1);
        @(negedge clk);
        do_start(9);
        send_pixel(5, 9, -3, 2);
        check_label("th9_p0", 1, 1'b0, 1'b0);
        send_pixel(-7, -7, -9, -8);
        check_label("th9_p1", 255, 1'b0, 1'b0);
        send_pixel(0, 1, 1, 0);
        @(negedge clk);
        check_idle("th9_end");

        // Backpressure: first label held while pixel 1 accumulates; its final beat stalls.
        do_start(-32768);
        send_pixel(5, 9, -3, 2);
        check_label("bp_p0", 1, 1'b0, 1'b0);
        m_ready = 1'b0;
        send_beat(-7, -7);
        check("bp_hold0_valid", {31'd0, m_valid}, 32'd1);
        check("bp_hold0_label", {24'd0, m_label}, 32'd1);
        s_valid = 1'b1;
        s_data  = {-16'sd8, -16'sd9};
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_stall_s_ready", {31'd0, s_ready}, 32'd0);
            @(negedge clk);
            check("bp_hold_valid", {31'd0, m_valid}, 32'd1);
            check("bp_hold_label", {24'd0, m_label}, 32'd1);
            check("bp_hold_last",  {31'd0, m_last},  32'd0);
        end
        m_ready = 1'b1;
        #1;
        check("bp_release_s_ready", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        check_label("bp_p1", 0, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_no_dup", {31'd0, m_valid}, 32'd0);
        send_pixel(0, 1, 1, 0);
        check_label("bp_p2", 1, 1'b1, 1'b1);
        @(negedge clk);
        check_idle("bp_end");

        // Reset in the middle of a frame discards it without a done pulse.
        do_start(-32768);
        send_pixel(5, 9, -3, 2);
        send_beat(-7, -7);
        rst_n = 1'b0;
        #1;
        check_idle("mid_rst");
        check("mid_rst_label", {24'd0, m_label}, 32'd0);
        check("mid_rst_last",  {31'd0, m_last},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean frame after reset; a second start while busy must not relatch thresh.
        do_start(-32768);
        start  = 1'b1;
        thresh = 16'sd32767;
        @(negedge clk);
        start  = 1'b0;
        thresh = '0;
        check("busy_start_ignored", {31'd0, busy}, 32'd1);
        send_pixel(5, 9, -3, 2);
        check_label("rs_p0", 1, 1'b0, 1'b0);
        send_pixel(-7, -7, -9, -8);
        check_label("rs_p1", 0, 1'b0, 1'b0);
        send_pixel(0, 1, 1, 0);
        check_label("rs_p2", 1, 1'b1, 1'b1);
        @(negedge clk);
        check_idle("rs_end");

`ifdef SEG_CONFIDENCE_EN
        do_start(-32768);
        send_pixel(32767, -32768, -32768, -32768);
        check_label("mg_p0", 0, 1'b0, 1'b0);
        check("mg_p0_margin", {16'd0, m_margin}, 32'd65535);
        send_pixel(0, 1, 1, 0);
        check("mg_p1_margin", {16'd0, m_margin}, 32'd0);
        send_pixel(5, 9, -3, 2);
        check("mg_p2_margin", {16'd0, m_margin}, 32'd4);
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_argmax_stream.md
SEG_ARGMAX_STREAM -- requirements
Module: seg_argmax_stream

Interface
REQ-001 Parameter NUM_CLASSES, default 21, number of class scores per pixel; must be a multiple of LANES.
REQ-002 Parameter LANES, default 3, scores delivered per input beat.
REQ-003 Parameter SCORE_W, default 16, width of each score, two's-complement signed.
REQ-004 Parameter NUM_PIXELS, default 50176, pixels per frame.
REQ-005 Parameter LABEL_W, default 8, label width; 2**LABEL_W must exceed NUM_CLASSES.
REQ-006 Parameter IGNORE_LABEL, default 255, label emitted for a low-confidence pixel.
REQ-007 clk  in  1  single clock; all logic on the rising edge.
REQ-008 rst_n  in  1  asynchronous reset, active-low.
REQ-009 start  in  1  one-cycle pulse that begins a frame.
REQ-010 thresh  in  SCORE_W  signed minimum winning score; sampled at start.
REQ-011 s_valid  in  1  input beat valid.
REQ-012 s_ready  out  1  input beat accepted when s_valid and s_ready are both high.
REQ-013 s_data  in  LANES*SCORE_W  scores for classes k*LANES to k*LANES+LANES-1; lane 0 in the LSBs.
REQ-014 m_valid  out  1  label valid.
REQ-015 m_ready  in  1  downstream accepts the label.
REQ-016 m_label  out  LABEL_W  argmax class index, or IGNORE_LABEL.
REQ-017 m_last  out  1  high with the label of pixel NUM_PIXELS-1.
REQ-018 busy  out  1  high in RUN and FLUSH.
REQ-019 done  out  1  one-cycle pulse when the frame completes.

Function
REQ-020 FSM states:
- IDLE: start -> RUN; beat and pixel counters cleared; thresh latched.
- RUN: after the final class beat of the last pixel is accepted -> FLUSH.
- FLUSH: when the m_m_last handshake occurs -> IDLE, with done high in that same cycle.
REQ-021 s_ready is 0 in IDLE and FLUSH.
REQ-022 In RUN, s_ready = !(final_beat && m_valid && !m_ready).
- final_beat means the beat counter equals NUM_CLASSES/LANES-1.
- Non-final beats are always accepted in RUN, so accumulation overlaps a pending output.
REQ-023 Per-beat compare:
- A combinational LANES-wide signed max selects the best lane, lowest lane winning ties.
- That lane is then compared against the running max with strict greater-than.
- Result: the lowest class index wins on equal scores.
REQ-024 On the first beat of a pixel, the running max is loaded from that beat's best lane. No compare is made against zero or against a stale value.
REQ-025 On acceptance of the final beat, the output register loads in the same cycle:
- m_label = winning index, or IGNORE_LABEL if the winning score is less than thresh (signed).
- m_valid goes high on the next cycle; latency is one cycle from the final beat.
REQ-026 m_label, m_last and m_valid hold stable while m_valid && !m_ready. m_valid falls after the handshake unless a new label loads in the same cycle.
REQ-027 Counters:
- Beat counter wraps to 0 after NUM_CLASSES/LANES-1.
- Pixel counter increments on each final beat and reaches NUM_PIXELS-1 on the last pixel.
- Counter widths are $clog2 of their range, minimum 1.
REQ-028 start while busy is ignored.
REQ-029 Beats arriving in IDLE are not accepted and produce no effect.
REQ-030 Overflow is not possible: indices fit in LABEL_W, and scores are compared only, never summed.

Reset
REQ-031 Asserting rst_n low at any time, including mid-frame, forces the following state; the partial frame is discarded with no done pulse:
- state IDLE;
- s_ready=0, m_valid=0, m_label=0, m_last=0, busy=0, done=0;
- counters and running max cleared.
REQ-032 Reset release is synchronised to clk by the surrounding design. The block accepts start no earlier than the first rising edge after release.

Configuration
REQ-033 With macro SEG_CONFIDENCE_EN defined:
- Extra output m_margin, out, SCORE_W, unsigned, equal to the winning score minus the second-highest score, saturated to 2**SCORE_W-1.
- The block tracks the second max; equal top scores give margin 0.
- m_margin resets to 0 and follows the same timing and stability rules as m_label.
REQ-034 Without SEG_CONFIDENCE_EN, the m_margin port and the second-max logic are absent; all other behaviour is identical.

Structure
REQ-035 Package seg_pkg holds the score type parameterised by SCORE_W, the FSM state encoding (IDLE/RUN/FLUSH) and the default IGNORE_LABEL.
REQ-036 Sub-module seg_lane_max is the combinational LANES-wide signed max. It returns the best score and lane index, plus the second-best when SEG_CONFIDENCE_EN is defined.

Verification
REQ-037 Base config for the directed scenarios: NUM_CLASSES=4, LANES=2, NUM_PIXELS=3, thresh=-32768, m_ready=1.
- Stimulus: pixel scores {5,9,-3,2}, {-7,-7,-9,-8}, {0,1,1,0}.
- Required: labels 1, 0, 1; m_last on the third label; done one cycle after the third final beat.
REQ-038 Threshold: thresh=10 with scores {5,9,-3,2} -> m_label=255. With thresh=9 -> m_label=1 (equal to thresh passes).
REQ-039 Backpressure: m_ready held 0 for 5 cycles after the first label.
- Required: first-beat data of pixel 1 accepted, final beat stalled (s_ready=0), label 1 held stable.
- When m_ready rises, no label is lost or duplicated.
REQ-040 Reset mid-frame: rst_n low after pixel 1 first beat -> all outputs reset next observation, no done. A new start then completes a clean 3-label frame.
REQ-041 SEG_CONFIDENCE_EN: scores {5,9,-3,2} -> m_margin=4; {-7,-7,-9,-8} -> m_margin=0; {32767,-32768,...} -> m_margin=65535.
